// File: rtl/bundler_readout_if.sv
// Handshake bundle for the bundler readout: start request from the requester
// and the chunk stream toward the downstream consumer.
interface bundler_readout_if #(
    parameter int ChunkWidth = 64,
    parameter int IdxWidth   = 3
);
    logic                  start_valid;
    logic                  start_ready;
    logic [ChunkWidth-1:0] chunk;
    logic [IdxWidth-1:0]   chunk_idx;
    logic                  chunk_last;
    logic                  chunk_valid;
    logic                  chunk_ready;

    // Requester/consumer side.
    modport master (
        output start_valid,
        input  start_ready,
        input  chunk,
        input  chunk_idx,
        input  chunk_last,
        input  chunk_valid,
        output chunk_ready
    );

    // Readout block side.
    modport slave (
        input  start_valid,
        output start_ready,
        output chunk,
        output chunk_idx,
        output chunk_last,
        output chunk_valid,
        input  chunk_ready
    );
endinterface

// File: rtl/bundler_readout.sv
// Snapshots signed bundle counters, thresholds them into a binary hypervector
// and streams it out chunk by chunk; optionally pulses a bundler clear at the end.
module bundler_readout #(
    parameter int HVDimension  = 512,
    parameter int CounterWidth = 8,
    parameter int ChunkWidth   = 64,
    localparam int NumChunks   = HVDimension / ChunkWidth,
    localparam int IdxWidth    = (NumChunks > 1) ? $clog2(NumChunks) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic signed [HVDimension-1:0][CounterWidth-1:0] counter_i,
    input  logic signed [CounterWidth-1:0]         threshold_i,
    input  logic [HVDimension-1:0]                 tie_hv_i,
    input  logic                                   clr_after_i,
    bundler_readout_if.slave                       rd_if,
    output logic [HVDimension-1:0]                 hv_o,
    output logic                                   busy_o,
    output logic                                   clr_o
);

    typedef enum logic {IDLE, SEND} state_e;

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumChunks - 1);

    state_e                             state_q, state_d;
    logic [HVDimension-1:0]             hv_q, hv_d;
    logic [IdxWidth-1:0]                idx_q, idx_d;
    logic                               clr_flag_q, clr_flag_d;
    logic                               clr_q, clr_d;
    logic [HVDimension-1:0]             hv_bin;
    logic [NumChunks-1:0][ChunkWidth-1:0] hv_chunks;
    logic                               is_last;

    // Binarization: above threshold -> 1, below -> 0, equal -> tie bit.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        hv_bin = '0;
        for (int i = 0; i < HVDimension; i++) begin
            if ($signed(counter_i[i]) > threshold_i) begin
                hv_bin[i] = 1'b1;
            end else if ($signed(counter_i[i]) < threshold_i) begin
                hv_bin[i] = 1'b0;
            end else begin
                hv_bin[i] = tie_hv_i[i];
            end
        end
    end

    assign hv_chunks = hv_q;
    assign is_last   = (idx_q == LastIdx);

    always_comb begin
        state_d    = state_q;
        hv_d       = hv_q;
        idx_d      = idx_q;
        clr_flag_d = clr_flag_q;
        clr_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_if.start_valid) begin
                    hv_d       = hv_bin;
                    clr_flag_d = clr_after_i;
                    idx_d      = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (rd_if.chunk_ready) begin
                    if (is_last) begin
                        state_d    = IDLE;
                        idx_d      = '0;
                        clr_d      = clr_flag_q;
                        clr_flag_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IdxWidth'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the hypervector register is reset too, since hv_o is visible and must read 0.
            state_q    <= IDLE;
            hv_q       <= '0;
            idx_q      <= '0;
            clr_flag_q <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hv_q       <= hv_d;
            idx_q      <= idx_d;
            clr_flag_q <= clr_flag_d;
            clr_q      <= clr_d;
        end
    end

    assign rd_if.start_ready = (state_q == IDLE);
    assign rd_if.chunk_valid = (state_q == SEND);
    assign rd_if.chunk       = hv_chunks[idx_q];
    assign rd_if.chunk_idx   = idx_q;
    // Gated with SEND so a single-chunk configuration does not flag last while idle.
    assign rd_if.chunk_last  = (state_q == SEND) && is_last;
    assign busy_o            = (state_q == SEND);
    assign hv_o              = hv_q;
    assign clr_o             = clr_q;

endmodule

// File: tb/tb_bundler_readout.sv
// Directed bench for bundler_readout at HVDimension=16, ChunkWidth=4, CounterWidth=4.
module tb_bundler_readout;

    localparam int HVD = 16;
    localparam int CW  = 4;
    localparam int CHW = 4;

    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b1;
    logic [HVD-1:0][CW-1:0]   counter;
    logic [CW-1:0]            threshold;
    logic [HVD-1:0]           tie_hv;
    logic                     clr_after;
    logic [HVD-1:0]           hv_o;
    logic                     busy_o;
    logic                     clr_o;

    int n_checks = 0;
    int n_fail   = 0;

    bundler_readout_if #(.ChunkWidth(CHW), .IdxWidth(2)) rd_if ();

    bundler_readout #(
        .HVDimension (HVD),
        .CounterWidth(CW),
        .ChunkWidth  (CHW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .counter_i  (counter),
        .threshold_i(threshold),
        .tie_hv_i   (tie_hv),
        .clr_after_i(clr_after),
        .rd_if      (rd_if),
        .hv_o       (hv_o),
        .busy_o     (busy_o),
        .clr_o      (clr_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_counters(input int vec[16]);
        for (int i = 0; i < HVD; i++) counter[i] = CW'(vec[i]);
    endtask

    // Accept with ready held high, check all four beats and the clear pulse.
    task automatic run_readout(input string tag, input logic [15:0] exp_hv, input logic exp_clr);
        rd_if.chunk_ready = 1'b1;
        rd_if.start_valid = 1'b1;
        check({tag, " start_ready"}, rd_if.start_ready, 1'b1);
        @(negedge clk_i);
        rd_if.start_valid = 1'b0;
        check({tag, " hv"}, hv_o, exp_hv);
        for (int k = 0; k < 4; k++) begin
            check({tag, " valid"}, rd_if.chunk_valid, 1'b1);
            check({tag, " busy"}, busy_o, 1'b1);
            check({tag, " idx"}, rd_if.chunk_idx, k);
            check({tag, " chunk"}, rd_if.chunk, exp_hv[k*4 +: 4]);
            check({tag, " last"}, rd_if.chunk_last, (k == 3));
            check({tag, " clr_mid"}, clr_o, 1'b0);
            @(negedge clk_i);
        end
        check({tag, " valid_end"}, rd_if.chunk_valid, 1'b0);
        check({tag, " ready_end"}, rd_if.start_ready, 1'b1);
        check({tag, " clr_pulse"}, clr_o, exp_clr);
        @(negedge clk_i);
        check({tag, " clr_after"}, clr_o, 1'b0);
        check({tag, " hv_hold"}, hv_o, exp_hv);
    endtask

    int vec_a[16] = '{3, -1, 0, 7, -8, 1, 0, -2, 0, 0, 0, 0, 0, 0, 0, 0};
    int vec_b[16] = '{2, 2, -8, 7, 3, -3, 2, 2, 1, 0, -1, 5, 6, -7, 2, 4};
    int vec_c[16] = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7, 7};

    initial begin
        logic [6:0] bp_pat;
        int         hs;
        logic [15:0] exp_hv;

        counter             = '0;
        threshold           = '0;
        tie_hv              = '0;
        clr_after           = 1'b0;
        rd_if.start_valid   = 1'b0;
        rd_if.chunk_ready   = 1'b0;

        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst hv", hv_o, 16'h0000);
        check("rst valid", rd_if.chunk_valid, 1'b0);
        check("rst last", rd_if.chunk_last, 1'b0);
        check("rst idx", rd_if.chunk_idx, 2'd0);
        check("rst busy", busy_o, 1'b0);
        check("rst clr", clr_o, 1'b0);
        check("rst start_ready", rd_if.start_ready, 1'b1);

        // Threshold 0, ties resolve to 1.
        load_counters(vec_a);
        threshold = 4'sd0;
        tie_hv    = 16'hFFFF;
        run_readout("t0", 16'hFF6D, 1'b0);

        // Threshold -1, ties resolve to 0: bit1 (counter -1) ties low, counter 0 maps high.
        threshold = 4'hF;
        tie_hv    = 16'h0000;
        run_readout("tm1", 16'hFF6D, 1'b0);

        // Signed compare against threshold 2 with mixed tie bits.
        load_counters(vec_b);
        threshold = 4'sd2;
        tie_hv    = 16'h5555;
        run_readout("t2", 16'hD859, 1'b0);

        // Backpressure pattern 0,0,1,0,1,1,1.
        exp_hv = 16'hD859;
        bp_pat = 7'b1110100;
        hs     = 0;
        rd_if.start_valid = 1'b1;
        @(negedge clk_i);
        rd_if.start_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            rd_if.chunk_ready = bp_pat[c];
            check("bp valid", rd_if.chunk_valid, 1'b1);
            check("bp idx", rd_if.chunk_idx, hs);
            check("bp chunk", rd_if.chunk, exp_hv[hs*4 +: 4]);
            check("bp start_ready", rd_if.start_ready, 1'b0);
            if (bp_pat[c]) hs++;
            @(negedge clk_i);
        end
        check("bp handshakes", hs, 4);
        check("bp valid_end", rd_if.chunk_valid, 1'b0);
        rd_if.chunk_ready = 1'b1;

        // Clear requested; inputs disturbed after accept must not matter.
        load_counters(vec_a);
        threshold = 4'sd0;
        tie_hv    = 16'hFFFF;
        clr_after = 1'b1;
        rd_if.start_valid = 1'b1;
        @(negedge clk_i);
        rd_if.start_valid = 1'b0;
        load_counters(vec_c);
        threshold = 4'h8;
        tie_hv    = 16'h0000;
        clr_after = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("clr chunk", rd_if.chunk, exp_hv_a(k));
            check("clr pulse_early", clr_o, 1'b0);
            @(negedge clk_i);
        end
        check("clr pulse", clr_o, 1'b1);
        check("clr start_ready", rd_if.start_ready, 1'b1);
        check("clr hv", hv_o, 16'hFF6D);
        @(negedge clk_i);
        check("clr pulse_width", clr_o, 1'b0);

        // Same with clear not requested.
        load_counters(vec_a);
        tie_hv    = 16'hFFFF;
        threshold = 4'sd0;
        clr_after = 1'b0;
        run_readout("noclr", 16'hFF6D, 1'b0);

        // start_valid held continuously: accept every 5 cycles.
        rd_if.start_valid = 1'b1;
        for (int c = 0; c < 15; c++) begin
            check("cont start_ready", rd_if.start_ready, (c % 5 == 0));
            check("cont busy", busy_o, (c % 5 != 0));
            @(negedge clk_i);
        end
        rd_if.start_valid = 1'b0;
        check("cont idle", rd_if.start_ready, 1'b1);
        @(negedge clk_i);

        // Reset after the second handshake of a clearing readout.
        clr_after = 1'b1;
        rd_if.start_valid = 1'b1;
        @(negedge clk_i);
        rd_if.start_valid = 1'b0;
        clr_after = 1'b0;
        @(negedge clk_i);
        check("mrst idx1", rd_if.chunk_idx, 2'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("mrst valid", rd_if.chunk_valid, 1'b0);
        check("mrst hv", hv_o, 16'h0000);
        check("mrst clr", clr_o, 1'b0);
        check("mrst start_ready", rd_if.start_ready, 1'b1);
        check("mrst idx", rd_if.chunk_idx, 2'd0);
        @(negedge clk_i);
        check("mrst clr_late", clr_o, 1'b0);
        run_readout("fresh", 16'hFF6D, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Expected beats of the vec_a / threshold 0 / tie all-ones snapshot (16'hFF6D).
    function automatic logic [3:0] exp_hv_a(input int k);
        logic [3:0] beats [4];
        beats = '{4'hD, 4'h6, 4'hF, 4'hF};
        return beats[k];
    endfunction

endmodule

// File: doc/bundler_readout.md
Name: bundler_readout

Overview:
- Read-side counterpart to the bundler set: takes a snapshot of the signed per-dimension bundle counters, thresholds it into a binary hypervector, and streams the result out in fixed-width chunks over a valid/ready handshake.
- Optionally issues a one-cycle clear request back to the bundler set once the last chunk has been consumed.
- Sits between the bundler set and the associative memory / output streamer.

Parameters:
- HVDimension, 512, hypervector width and counter count; must be a multiple of ChunkWidth.
- CounterWidth, 8, width of each signed two's-complement counter.
- ChunkWidth, 64, output beat width in bits.
- Derived, not overridable: NumChunks = HVDimension/ChunkWidth; IdxWidth = max(1, $clog2(NumChunks)).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- counter_i  in  signed [HVDimension-1:0][CounterWidth-1:0]  counter vector from the bundler set.
- threshold_i  in  signed [CounterWidth-1:0]  binarization threshold.
- tie_hv_i  in  [HVDimension-1:0]  tie-break bits used where counter == threshold.
- clr_after_i  in  1  request a bundler clear after readout.
- start_valid_i  in  1  readout request.
- start_ready_o  out  1  request accepted when high; high only in IDLE.
- chunk_o  out  [ChunkWidth-1:0]  current output chunk.
- chunk_idx_o  out  [IdxWidth-1:0]  index of the current chunk.
- chunk_last_o  out  1  current chunk is chunk NumChunks-1.
- chunk_valid_o  out  1  chunk_o is valid.
- chunk_ready_i  in  1  downstream accepts the chunk.
- hv_o  out  [HVDimension-1:0]  full binarized hypervector register.
- busy_o  out  1  high while in SEND.
- clr_o  out  1  one-cycle clear pulse to the bundler set.

Behaviour:
- Reset values:
  - State IDLE.
  - hv_o=0, chunk index=0, chunk_valid_o=0, chunk_last_o=0, busy_o=0, clr_o=0.
  - Latched clr_after flag = 0.
  - start_ready_o=1 in the cycle after reset is released.
- States: IDLE and SEND.
- IDLE:
  - start_ready_o=1.
  - On start_valid_i && start_ready_o at edge N:
    - register hv_o[i] = (counter_i[i] > threshold_i) ? 1 : (counter_i[i] < threshold_i) ? 0 : tie_hv_i[i]. The comparison is signed at CounterWidth.
    - latch clr_after_i.
    - index = 0.
    - go to SEND.
  - counter_i, threshold_i, tie_hv_i and clr_after_i are sampled only at accept; later changes have no effect.
- SEND:
  - chunk_valid_o=1 and busy_o=1, starting the cycle after edge N (accept-to-first-valid latency is 1 cycle).
  - chunk_o = hv_o[idx*ChunkWidth +: ChunkWidth]; chunk_idx_o = idx; chunk_last_o = (idx == NumChunks-1).
  - chunk_o, chunk_idx_o and chunk_last_o are held stable while chunk_valid_o && !chunk_ready_i.
  - chunk_valid_o never drops without a handshake, except on reset.
  - Each handshake (chunk_valid_o && chunk_ready_i) increments idx; one beat per cycle when ready is held high.
  - Handshake on the last chunk:
    - go to IDLE; idx wraps to 0.
    - clr_o=1 for exactly the next cycle if the latched flag is set, else 0.
    - clear the latched flag.
- Minimum request-to-request period is NumChunks+1 cycles. start_ready_o is high in the cycle after the last handshake.
- A new start accepted in the same cycle that clr_o is high is legal. It samples the pre-clear counters, because the bundler clear takes effect at the following edge. This hazard is the integrator's responsibility.
- NumChunks == 1: the first beat is also last; chunk_last_o=1 and chunk_idx_o=0.
- Reset asserted mid-SEND:
  - all registers return to reset values the next edge.
  - chunk_valid_o drops and no clr_o is issued.
  - the partial readout is discarded.
- start_valid_i during SEND is ignored (start_ready_o=0); the requester must hold it.
- hv_o holds its value after readout until the next accept.

Test Plan:
- Config HVDimension=16, ChunkWidth=4, CounterWidth=4, threshold 0, ready held high. Counters [+3,-1,0,+7, -8,+1,0,-2, +0..] with tie_hv_i=16'hFFFF. Required: hv_o[7:0]=8'b0110_1101 one cycle after accept; chunks 4'b1101, 4'b0110, ... on 4 consecutive cycles; idx 0..3; last only on idx 3.
- Same stimulus with tie_hv_i=0 and threshold_i=-1. Required: ties now fall on counter == -1 (bit 1 gets tie value 0); counter 0 maps to 1.
- Backpressure: chunk_ready_i toggled 0,0,1,0,1,1,1. Required: each chunk held stable while ready=0; exactly 4 handshakes; chunk_o and chunk_idx_o never change without a handshake.
- clr_after_i=1 at accept, then counter_i changed mid-SEND. Required: output unchanged; clr_o high for exactly 1 cycle after the idx-3 handshake; start_ready_o high in that same cycle. Repeat with clr_after_i=0: clr_o stays 0.
- start_valid_i held high continuously. Required: accepts every NumChunks+1=5 cycles; start_ready_o low throughout SEND.
- rst_i pulsed after the 2nd handshake. Required: next cycle chunk_valid_o=0, hv_o=0, clr_o=0, start_ready_o=1; a following start produces a fresh readout starting at idx 0.
